// File: rtl/present_pkg.sv
// Shared constants and types for the PRESENT-128 iterative core.
package present_pkg;

  // Full PRESENT round count before the final key whitening.
  localparam int unsigned NROUNDS          = 31;
  // Rounds the datapath folds into one clock cycle.
  localparam int unsigned ROUNDS_PER_CYCLE = 1;
  // Datapath update cycles needed for one block.
  localparam int unsigned ROUND_CYCLES     = NROUNDS / ROUNDS_PER_CYCLE;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/present_ctrl.sv
// Sequencing controller for the PRESENT-128 iterative datapath: accepts one
// plaintext/key pair, steps the datapath through every round, captures the
// ciphertext and hands it out over a valid/ready port.
module present_ctrl
  import present_pkg::*;
#(
  parameter int unsigned ROUND_CYCLES = present_pkg::ROUND_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   plaintext,
  input  logic [127:0]  key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   ciphertext,
  output logic          busy,
  output logic          dp_ld,
  output logic [63:0]   dp_plaintext,
  output logic [127:0]  dp_key,
  output logic [4:0]    dp_round,
  input  logic [63:0]   dp_ciphertext
);

  // The datapath is built for single-round-per-cycle operation only.
  if (ROUND_CYCLES != 31) begin : g_bad_round_cycles
    $error("present_ctrl: only ROUND_CYCLES = 31 is supported");
  end

  localparam logic [4:0] LastRound = 5'(ROUND_CYCLES);

  ctrl_state_t state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] ct_q, ct_d;

  // Next-state logic: accept, count rounds, capture, wait for the consumer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ct_d    = ct_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StRun;
          cnt_d   = 5'd1;
        end
      end
      StRun: begin
        // Counter saturates at the last round instead of wrapping.
        if (cnt_q == LastRound) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StCapture: begin
        ct_d    = dp_ciphertext;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // State, round counter and result register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      ct_q    <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ct_q    <= ct_d;
    end
  end

  // Handshake and datapath control decoded from the current state.
  always_comb begin
    // Suppress acceptance while reset is held so no load escapes a reset cycle.
    in_ready     = (state_q == StIdle) && !rst;
    dp_ld        = in_ready && in_valid;
    dp_round     = (state_q == StRun) ? cnt_q : 5'd0;
    out_valid    = (state_q == StDone);
    busy         = (state_q == StRun) || (state_q == StCapture);
    ciphertext   = ct_q;
    dp_plaintext = plaintext;
    dp_key       = key;
  end

endmodule

// File: tb/tb_present_ctrl.sv
// Bench for present_ctrl: a behavioural PRESENT-128 datapath hangs off the dp_*
// ports, an input monitor pushes golden results on every accept and an output
// monitor pops and compares on every result handshake.
module tb_present_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  ciphertext;
  logic         busy;
  logic         dp_ld;
  logic [63:0]  dp_plaintext;
  logic [127:0] dp_key;
  logic [4:0]   dp_round;
  logic [63:0]  dp_ciphertext;

  present_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .plaintext     (plaintext),
    .key           (key),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .ciphertext    (ciphertext),
    .busy          (busy),
    .dp_ld         (dp_ld),
    .dp_plaintext  (dp_plaintext),
    .dp_key        (dp_key),
    .dp_round      (dp_round),
    .dp_ciphertext (dp_ciphertext)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_out  = 0;

  // ---------------- PRESENT-128 reference functions ----------------
  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: sb = 4'hC; 4'h1: sb = 4'h5; 4'h2: sb = 4'h6; 4'h3: sb = 4'hB;
      4'h4: sb = 4'h9; 4'h5: sb = 4'h0; 4'h6: sb = 4'hA; 4'h7: sb = 4'hD;
      4'h8: sb = 4'h3; 4'h9: sb = 4'hE; 4'hA: sb = 4'hF; 4'hB: sb = 4'h8;
      4'hC: sb = 4'h4; 4'hD: sb = 4'h7; 4'hE: sb = 4'h1; default: sb = 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] round_fn(input logic [63:0] s, input logic [63:0] rk);
    logic [63:0] t;
    logic [63:0] y;
    t = s ^ rk;
    for (int i = 0; i < 16; i++) t[i*4 +: 4] = sb(t[i*4 +: 4]);
    y = '0;
    for (int i = 0; i < 63; i++) y[(i * 16) % 63] = t[i];
    y[63] = t[63];
    return y;
  endfunction

  function automatic logic [127:0] key_upd(input logic [127:0] k, input logic [4:0] rc);
    logic [127:0] n;
    n = {k[66:0], k[127:67]};
    n[127:124] = sb(n[127:124]);
    n[123:120] = sb(n[123:120]);
    n[66:62]   = n[66:62] ^ rc;
    return n;
  endfunction

  function automatic logic [63:0] golden(input logic [63:0] pt, input logic [127:0] k);
    logic [63:0]  s;
    logic [127:0] kk;
    s  = pt;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s  = round_fn(s, kk[127:64]);
      kk = key_upd(kk, 5'(r));
    end
    return s ^ kk[127:64];
  endfunction

  // ---------------- behavioural datapath ----------------
  logic [63:0]  dst  = '0;
  logic [127:0] dkey = '0;
  always @(posedge clk) begin
    if (dp_ld) begin
      dst  <= dp_plaintext;
      dkey <= dp_key;
    end else if (dp_round != 5'd0) begin
      dst  <= round_fn(dst, dkey[127:64]);
      dkey <= key_upd(dkey, dp_round);
    end
  end
  assign dp_ciphertext = dst ^ dkey[127:64];

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [63:0] ct;
    int          acc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Input monitor: every accepted pair yields one expected result.
  always @(negedge clk) begin
    if (in_valid && in_ready) sbq.push_back('{ct: golden(plaintext, key), acc: cyc});
  end

  // Output monitor: latency on the rising edge of out_valid, value on handshake.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (sbq.size() == 0) chk("spurious_out_valid", 64'd1, 64'd0);
      else chk("latency", 64'(cyc - sbq[0].acc), 64'd33);
    end
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        chk("ciphertext", ciphertext, sbq[0].ct);
        void'(sbq.pop_front());
        n_out++;
      end
    end
    prev_ov = out_valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [63:0] pt, input logic [127:0] k, output logic ld_at_acc);
    bit got;
    got = 0;
    ld_at_acc = 1'b0;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    plaintext = pt;
    key       = k;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        ld_at_acc = dp_ld;
      end
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit got;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready && !out_valid) got = 1;
    end
    if (!got) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_out_valid();
    bit got;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1;
    end
    if (!got) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  localparam logic [63:0]  ZeroCt = 64'h96db702a2e6900af;
  localparam logic [63:0]  OnesPt = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] OnesK  = {128{1'b1}};

  initial begin
    logic ld;
    logic [63:0] exp3;
    int a1;
    int a2;
    int ld_cnt;
    bit got;
    rst       = 1'b1;
    in_valid  = 1'b0;
    plaintext = '0;
    key       = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dp_ld", 64'(dp_ld), 64'd0);
    chk("rst_dp_round", 64'(dp_round), 64'd0);
    chk("rst_ciphertext", ciphertext, 64'd0);

    // Zero plaintext, zero key against the published vector
    issue(64'd0, 128'd0, ld);
    wait_idle();
    chk("golden_zero_vector", golden(64'd0, 128'd0), ZeroCt);

    // All-ones pair with a round trace
    issue(OnesPt, OnesK, ld);
    ld_cnt = int'(ld);
    chk("ld_at_accept", 64'(ld), 64'd1);
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      chk($sformatf("dp_round_%0d", k), 64'(dp_round), 64'(k));
      ld_cnt += int'(dp_ld);
    end
    @(negedge clk);
    chk("capture_dp_round", 64'(dp_round), 64'd0);
    chk("capture_busy", 64'(busy), 64'd1);
    ld_cnt += int'(dp_ld);
    chk("dp_ld_pulses", 64'(ld_cnt), 64'd1);
    wait_idle();

    // Consumer stalls for 10 cycles in DONE
    out_ready = 1'b0;
    exp3 = golden(64'h0123456789abcdef, 128'h00112233445566778899aabbccddeeff);
    issue(64'h0123456789abcdef, 128'h00112233445566778899aabbccddeeff, ld);
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_ciphertext", ciphertext, exp3);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle();

    // in_valid held high with a second pair pending: 34-cycle issue interval
    @(posedge clk); #1;
    in_valid  = 1'b1;
    plaintext = 64'hdeadbeefcafef00d;
    key       = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    got = 0;
    a1 = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; a1 = cyc; end
    end
    if (!got) chk("b2b_first_accept", 64'd0, 64'd1);
    @(posedge clk); #1;
    plaintext = 64'h0000000000000001;
    key       = OnesK;
    got = 0;
    a2 = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; a2 = cyc; end
    end
    if (!got) chk("b2b_second_accept", 64'd0, 64'd1);
    chk("issue_interval", 64'(a2 - a1), 64'd34);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();

    // Reset while RUN holds counter 15
    issue(OnesPt, 128'd0, ld);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (dp_round == 5'd14) got = 1;
    end
    if (!got) chk("reach_round_14", 64'd0, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_reset_round", 64'(dp_round), 64'd15);
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_dp_round", 64'(dp_round), 64'd0);
    issue(64'd0, 128'd0, ld);
    wait_out_valid();
    chk("after_rst_zero_ct", ciphertext, ZeroCt);
    wait_idle();

    // in_valid pulses during RUN and DONE are ignored
    out_ready = 1'b0;
    issue(64'h8000000000000000, 128'h1, ld);
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      chk($sformatf("pulse_round_%0d", k), 64'(dp_round), 64'(k));
      if (k == 10) begin
        chk("run_pulse_in_ready", 64'(in_ready), 64'd0);
        chk("run_pulse_dp_ld", 64'(dp_ld), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      if (k == 9) begin
        @(posedge clk); #1;
        in_valid  = 1'b1;
        plaintext = 64'h5555555555555555;
      end
    end
    wait_out_valid();
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("done_pulse_in_ready", 64'(in_ready), 64'd0);
    chk("done_pulse_dp_ld", 64'(dp_ld), 64'd0);
    chk("done_pulse_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    repeat (3) @(negedge clk);
    chk("result_count", 64'(n_out), 64'd7);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
